// File: rtl/seg_pipe_acc_if.sv
// Bus bundle for seg_pipe_acc: skewed segment inputs plus the aligned result.
// o_valid qualifies o_carry/o_sum for exactly one cycle; there is no ready, so a word is taken every cycle.
interface seg_pipe_acc_if #(
  parameter int P_INPUT_WIDTH = 6
);
  localparam int W = 4 * P_INPUT_WIDTH;

  logic [P_INPUT_WIDTH-1:0] i_lsb;
  logic [P_INPUT_WIDTH-1:0] i_isb2;
  logic [P_INPUT_WIDTH-1:0] i_isb1;
  logic [P_INPUT_WIDTH-1:0] i_msb;
  logic                     i_en;
  logic                     i_clr;
  logic                     o_carry;
  logic [W-1:0]             o_sum;
  logic                     o_valid;

  modport master (
    output i_lsb, i_isb2, i_isb1, i_msb, i_en, i_clr,
    input  o_carry, o_sum, o_valid
  );

  modport slave (
    input  i_lsb, i_isb2, i_isb1, i_msb, i_en, i_clr,
    output o_carry, o_sum, o_valid
  );
endinterface

// File: rtl/seg_pipe_acc.sv
// Four-segment carry-pipelined accumulator with deskewed W-bit output and msb carry-out.
// Optional carry-in dither from a 15-bit LFSR is compiled in with the DITHER_EN macro.
module seg_pipe_acc #(
  parameter int          P_INPUT_WIDTH = 6,
  parameter logic [14:0] P_LFSR_SEED   = 15'h4A5B
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  seg_pipe_acc_if.slave  acc_if
);
  localparam int P = P_INPUT_WIDTH;

  typedef logic [P-1:0] seg_t;

  // Stage index: 0 = lsb, 1 = isb2, 2 = isb1, 3 = msb.
  seg_t       r_acc [4];
  logic [3:0] r_c;
  logic [4:1] r_en_d;
  logic [3:1] r_clr_d;

  seg_t r_lsb_d1, r_lsb_d2, r_lsb_d3;
  seg_t r_isb2_d1, r_isb2_d2;
  seg_t r_isb1_d1;

  seg_t       w_in  [4];
  logic [P:0] w_sum [4];
  logic [3:0] w_en;
  logic [3:0] w_clr;
  logic [3:0] w_cin;
  logic       w_cin0;

`ifdef DITHER_EN
  logic [14:0] r_lfsr;
  logic        w_fb;

  // x^15 + x^14 + 1, shifted toward the msb; bit 0 is the dither carry-in.
  assign w_fb = r_lfsr[14] ^ r_lfsr[13];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= P_LFSR_SEED;
    end else if (acc_if.i_en) begin
      r_lfsr <= {r_lfsr[13:0], w_fb};
    end
  end

  assign w_cin0 = r_lfsr[0];
`else
  logic w_unused_seed;
  assign w_unused_seed = ^P_LFSR_SEED;
  assign w_cin0        = 1'b0;
`endif

  always_comb begin
    w_in[0] = acc_if.i_lsb;
    w_in[1] = acc_if.i_isb2;
    w_in[2] = acc_if.i_isb1;
    w_in[3] = acc_if.i_msb;
    w_en    = {r_en_d[3:1], acc_if.i_en};
    w_clr   = {r_clr_d[3:1], acc_if.i_clr};
    w_cin   = {r_c[2:0], w_cin0};
    for (int k = 0; k < 4; k++) begin
      w_sum[k] = {1'b0, r_acc[k]} + {1'b0, w_in[k]} + {{P{1'b0}}, w_cin[k]};
    end
  end

  // Each stage sees the en/clr of the word whose segment is currently on its input.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_acc[k] <= '0;
      end
      r_c <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_clr[k]) begin
          r_acc[k] <= '0;
          r_c[k]   <= 1'b0;
        end else if (w_en[k]) begin
          r_acc[k] <= w_sum[k][P-1:0];
          r_c[k]   <= w_sum[k][P];
        end else begin
          r_c[k]   <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_en_d    <= '0;
      r_clr_d   <= '0;
      r_lsb_d1  <= '0;
      r_lsb_d2  <= '0;
      r_lsb_d3  <= '0;
      r_isb2_d1 <= '0;
      r_isb2_d2 <= '0;
      r_isb1_d1 <= '0;
    end else begin
      r_en_d    <= {r_en_d[3:1], acc_if.i_en};
      r_clr_d   <= {r_clr_d[2:1], acc_if.i_clr};
      r_lsb_d1  <= r_acc[0];
      r_lsb_d2  <= r_lsb_d1;
      r_lsb_d3  <= r_lsb_d2;
      r_isb2_d1 <= r_acc[1];
      r_isb2_d2 <= r_isb2_d1;
      r_isb1_d1 <= r_acc[2];
    end
  end

  // Deskew lands every segment of word n in the same cycle the msb stage finishes it.
  assign acc_if.o_sum   = {r_acc[3], r_isb1_d1, r_isb2_d2, r_lsb_d3};
  assign acc_if.o_carry = r_c[3];
  assign acc_if.o_valid = r_en_d[4];
endmodule
